// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg
// Shared types and constants for the fractal synchronization network.
//   fsync_t                  : synchronization request element carried through
//                              the network and buffered ahead of the arbiter.
//   FSYNC_FIFO_DEFAULT_DEPTH : input queue depth that the arbiter wrappers and
//                              their per-port FIFOs agree on.
package fractal_sync_pkg;

  typedef logic [7:0] fsync_t;

  localparam int unsigned FSYNC_FIFO_DEFAULT_DEPTH = 4;

endpackage : fractal_sync_pkg

// File: rtl/fractal_sync_fifo.sv
// fractal_sync_fifo
// First-word-fall-through request queue placed on each synchronization arbiter
// input port. The arbiter looks at the head combinationally and pops in the
// same cycle; all outputs come from registered state only, so the loop
// empty_o -> pop_i closes without a combinational cycle.
//
// Ports
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset (discards all entries)
//   push_i      : write request, accepted when the queue is not full
//   element_i   : element written on an accepted push
//   full_o      : queue holds DEPTH entries
//   pop_i       : remove the head at the next clock edge (ignored when empty)
//   empty_o     : queue holds no entries
//   element_o   : head element, '0 while empty
//   level_o     : current occupancy
//   overflow_o  : one-cycle pulse, the cycle after a push was dropped
//   underflow_o : one-cycle pulse, the cycle after a pop was ignored
module fractal_sync_fifo #(
  parameter int unsigned DEPTH   = fractal_sync_pkg::FSYNC_FIFO_DEFAULT_DEPTH,
  parameter type         fsync_t = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  fsync_t                     element_i,
  output logic                       full_o,
  input  logic                       pop_i,
  output logic                       empty_o,
  output fsync_t                     element_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_depth_check
    $fatal(1, "fractal_sync_fifo: DEPTH must be at least 2");
  end

  // Pointers wrap explicitly so non-power-of-two depths index correctly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  fsync_t            mem_q [DEPTH];
  fsync_t            mem_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push_acc, pop_acc;

  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == CntW'(DEPTH));
  assign level_o     = cnt_q;
  assign element_o   = empty_o ? fsync_t'('0) : mem_q[rd_ptr_q];
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  // Full is judged on the registered count, so a pop in the same cycle never
  // makes room for a push.
  always_comb begin
    push_acc    = push_i && !full_o;
    pop_acc     = pop_i && !empty_o;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    overflow_d  = push_i && full_o;
    underflow_d = pop_i && empty_o;

    if (push_acc) begin
      mem_d[wr_ptr_q] = element_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_acc) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({push_acc, pop_acc})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage carries no reset; the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule : fractal_sync_fifo

// File: doc/fractal_sync_fifo.md
# fractal_sync_fifo

Per-port first-word-fall-through (FWFT) queue that buffers fractal synchronization requests ahead of the synchronization arbiter. One instance sits on each arbiter input port. The arbiter sees the head element combinationally, decides a grant, and pops in the same cycle. The upstream network pushes one request per cycle when the queue is not full.

## Interface
- `DEPTH`, default 4: number of entries. Must be ≥ 2; non-power-of-two values are legal.
- `fsync_t`, default `logic`: element type, taken from `fractal_sync_pkg`.
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `push_i`, input, 1: write request, sampled on `posedge clk_i`.
- `element_i`, input, `$bits(fsync_t)`: data written on an accepted push.
- `full_o`, output, 1: queue holds `DEPTH` entries.
- `pop_i`, input, 1: remove the head at the next clock edge. It may depend combinationally on `element_o` and `empty_o`.
- `empty_o`, output, 1: queue holds 0 entries.
- `element_o`, output, `$bits(fsync_t)`: head element. Drives `'0` while empty.
- `level_o`, output, `$clog2(DEPTH+1)`: current occupancy.
- `overflow_o`, output, 1: one-cycle pulse when a push is dropped.
- `underflow_o`, output, 1: one-cycle pulse when a pop is ignored.

## Operation
- Storage is `DEPTH` × `fsync_t` registers with a write pointer `wr_ptr` and read pointer `rd_ptr`. Each pointer is `max(1,$clog2(DEPTH))` bits and an occupancy counter `cnt` is `$clog2(DEPTH+1)` bits.
- Pointer increment wraps explicitly: `ptr == DEPTH-1` → 0, otherwise `ptr+1`. Do not rely on natural overflow.
- Push is accepted iff `push_i && !full_o`. Write `element_i` at `mem[wr_ptr]` and advance `wr_ptr`.
- Pop is accepted iff `pop_i && !empty_o`. Advance `rd_ptr`.
- Occupancy: `cnt` increments on push-only, decrements on pop-only, and holds on push+pop or when neither is accepted.
- Flags are derived from the registered count only: `empty_o = (cnt == 0)`, `full_o = (cnt == DEPTH)`, `level_o = cnt`.
- Full with push and pop in the same cycle: the push is dropped. `full_o` is a registered-state flag, so a same-cycle pop does not make room. `overflow_o` pulses and the pop is still accepted.
- Empty with a push: no bypass. The element appears on `element_o` one cycle later.
- Empty with a pop: ignored, state unchanged, `underflow_o` pulses.
- `element_o = empty_o ? '0 : mem[rd_ptr]`. This is a purely combinational read of the registered state.
- `overflow_o` and `underflow_o` are registered pulses, asserted in the cycle after the offending request.
- Reset values: `wr_ptr = rd_ptr = cnt = 0`, `empty_o = 1`, `full_o = 0`, `level_o = 0`, `element_o = '0`, `overflow_o = underflow_o = 0`. Storage is not reset.
- Reset asserted mid-operation discards all entries immediately (asynchronous). No pulses are generated by the reset itself.

## Timing
- Push → visible: an accepted push at edge N gives `empty_o = 0` and the valid `element_o` after edge N.
- Pop → next head: after the edge, `element_o` shows the next entry, or `'0` if the queue became empty.
- Full throughput: one push and one pop per cycle sustained at any non-empty, non-full level.
- There is no combinational path from `push_i` or `element_i` to any output.
- `pop_i` → outputs: no combinational path. This lets the arbiter close the loop `empty_o` → `pop_i` in the same cycle.

## Structure
- No new typedefs. `fsync_t` remains defined in `fractal_sync_pkg` and is passed as a parameter.
- Add `FSYNC_FIFO_DEFAULT_DEPTH = 4` to `fractal_sync_pkg` so that wrappers instantiating the arbiter and the FIFOs agree on the depth.
- Leaf module with no sub-modules.
- The wrapper instantiates `IN_PORTS` copies and connects `empty_o`/`element_o`/`pop_i` directly to the arbiter's `empty_i`/`element_i`/`pop_o`.
- Elaboration assertion: `DEPTH >= 2`, else `$fatal`.

## Test plan
- **Reset:** after `rst_ni` is released, `empty_o = 1`, `full_o = 0`, `level_o = 0`, `element_o = 0`. Then push `0xA` for 1 cycle → next cycle `empty_o = 0`, `element_o = 0xA`, `level_o = 1`.
- **Fill and overflow (`DEPTH = 4`):** push 1,2,3,4, then push 5 → `full_o = 1` after 4 pushes. `overflow_o` pulses once. Popping 4 times yields 1,2,3,4, then `empty_o = 1`.
- **Underflow:** pop on an empty queue → `underflow_o` pulses 1 cycle, `level_o` stays 0, and pointers are unchanged. Verify the next push/pop still returns the correct data.
- **Concurrent traffic:**
  - At `level_o = 2`, push and pop every cycle for 10 cycles → `level_o` stays 2 and the data order is preserved.
  - At full, push+pop in the same cycle → the pop is accepted, the push is dropped, `overflow_o` pulses, and `level_o = 3`.
- **Wrap-around with `DEPTH = 3`:** 20 random push/pop cycles are checked against a reference queue model. All pointers wrap 2 → 0 with no data corruption.
- **Reset mid-operation:** with `level_o = 3`, assert `rst_ni` low for 1 cycle → outputs return to the reset values immediately. After release, a push of `0x7` appears at the head one cycle later.
